axis_fifo_wr_arb: RTL and testbench
===================================

# axis_fifo_wr_arb

Packet-atomic round-robin arbiter that shares the single write port of the AXI-Stream async data FIFO among `NUM_SRC` AXI-Stream sources in the write clock domain. It grants one source at a time and holds the grant until that source's `tlast` beat is written. It forwards beats as `{tlast, tdata}` into the FIFO write port, honouring `full`, so packets never interleave in the FIFO.

## Interface
- `NUM_SRC`, 4: number of requesting sources (2..8).
- `DATA_WIDTH`, 31: tdata width per source.
- `FIFO_WIDTH`, `DATA_WIDTH+1`: FIFO word width; MSB carries tlast.
- `PKT_CNT_W`, 16: width of packet counter.

- `wr_clk`, in, 1: write-domain clock; the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `s_tvalid`, in, NUM_SRC: per-source valid.
- `s_tdata`, in, NUM_SRC*DATA_WIDTH: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_tlast`, in, NUM_SRC: per-source end of packet.
- `s_tready`, out, NUM_SRC: per-source ready.
- `full`, in, 1: FIFO full flag (write domain).
- `wr_en`, out, 1: FIFO write enable.
- `wr_data`, out, FIFO_WIDTH: `{s_tlast[g], s_tdata[g]}` of granted source g.
- `grant`, out, NUM_SRC: one-hot registered grant; all zero when idle.
- `busy`, out, 1: high in ARB_LOCK.
- `pkt_cnt`, out, PKT_CNT_W: packets written since reset, wraps.

## Operation
- States:
  - ARB_IDLE: no grant.
  - ARB_LOCK: grant held by source g.
- ARB_IDLE → ARB_LOCK when any `s_tvalid` is high.
  - Winner is the first set bit of `s_tvalid` searching upward from `rr_ptr`, wrapping modulo NUM_SRC.
  - `grant` and `g` are registered on that edge.
- In ARB_LOCK:
  - `s_tready[g] = ~full`; all other `s_tready` bits are 0.
  - `wr_en = s_tvalid[g] & ~full`.
  - `wr_data` is driven from source g combinationally; it is don't-care when `wr_en`=0, but is never X-propagating from unselected sources.
- ARB_LOCK → ARB_IDLE on the edge where `wr_en & s_tlast[g]`. On that edge:
  - `rr_ptr` becomes (g+1) mod NUM_SRC.
  - `pkt_cnt` increments.
- `s_tvalid[g]` dropping mid-packet does not release the grant. There is no timeout.
- `full` mid-packet stalls the transfer: `s_tready[g]`=0, `wr_en`=0, grant held.
- Single-beat packets are legal: first beat has tlast, giving LOCK for one accepting cycle.
- A non-granted source holding `tvalid` keeps waiting. Its data is never written.
- Reset mid-packet:
  - Grant drops immediately (async).
  - The partial packet already in the FIFO is not removed; upstream is responsible for that.
- `pkt_cnt` wraps from all-ones to 0.

## Timing
- Reset values:
  - state ARB_IDLE
  - `grant`=0
  - `busy`=0
  - `s_tready`=0
  - `wr_en`=0
  - `wr_data`=0
  - `rr_ptr`=0
  - `pkt_cnt`=0
- Arbitration latency:
  - Request visible at edge N gives `grant` at N+1.
  - The first beat can be written in cycle N+1.
- The cycle after the tlast beat is ARB_IDLE. This is one bubble between consecutive packets, including the same source re-requesting.
- `s_tready`, `wr_en` and `wr_data` are combinational from registered grant, `full` and source inputs. There is no data-path register.
- `grant`, `busy`, `rr_ptr` and `pkt_cnt` are registered.

## Structure
- Package `axis_arb_pkg`:
  - `arb_state_t` enum {ARB_IDLE, ARB_LOCK}.
  - Default `NUM_SRC`/`DATA_WIDTH` constants.
- Sub-module `rr_pick`: combinational rotating-priority picker. Inputs are the req vector and `rr_ptr`; outputs are a one-hot winner plus an index.
- The top holds the FSM, the grant/index registers, the mux and the counter.

## Test plan
- **Reset:** assert `rst` mid-simulation → all outputs 0 asynchronously, `pkt_cnt`=0, `rr_ptr`=0.
- **Round-robin:** all four sources hold 2-beat packets continuously → grant order 0,1,2,3,0. Each packet's two beats are contiguous, with one idle cycle between packets. `pkt_cnt`=5 after 5 packets.
- **Backpressure:** source 2 sends a 4-beat packet (0xA..0xD) and `full` is held high for 3 cycles after beat 2 → `wr_en` and `s_tready[2]` stay 0 for exactly 3 cycles, grant holds, and the FIFO receives 0xA,0xB,0xC,0xD with tlast only on 0xD.
- **Single-beat packets:** source 1 sends back-to-back single-beat packets while source 3 also requests → grants alternate 1,3,1. Each LOCK lasts one cycle.
- **Valid gap:** source 0 drops `tvalid` for 5 cycles mid-packet while source 1 requests → grant stays 0, source 1 sees no ready, and source 1 is granted only after source 0's tlast.
- **Counter wrap:** preload the counter to 0xFFFF via a force, then complete one packet → `pkt_cnt`=0x0000.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the packet-atomic FIFO write-port arbiter.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_DATA_WIDTH = 31;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr_i,
// wrapping modulo N. Returns one-hot winner, its index and a found flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o,
  output logic [IW-1:0] win_idx_o,
  output logic          win_vld_o
);

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!win_vld_o && req_i[(int'(ptr_i) + k) % N]) begin
        win_vld_o                          = 1'b1;
        win_idx_o                          = IW'((int'(ptr_i) + k) % N);
        win_oh_o[(int'(ptr_i) + k) % N]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_fifo_wr_arb.sv
// Packet-atomic round-robin arbiter feeding one FIFO write port from NUM_SRC
// AXI-Stream sources; the grant is held until the granted source's tlast beat.
module axis_fifo_wr_arb
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_WIDTH = DATA_WIDTH + 1,
  parameter int PKT_CNT_W  = 16
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            s_tvalid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]            s_tlast,
  output logic [NUM_SRC-1:0]            s_tready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         wr_data,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic [PKT_CNT_W-1:0]          pkt_cnt
);

  localparam int IW = idx_w(NUM_SRC);

  arb_state_t           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  logic [NUM_SRC-1:0]    pick_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_vld;
  logic                  sel_vld;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req_i     (s_tvalid),
    .ptr_i     (rr_ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .win_vld_o (pick_vld)
  );

  // Only the granted lane is selected, so unselected sources never reach wr_data.
  assign sel_vld  = s_tvalid[idx_q];
  assign sel_last = s_tlast[idx_q];
  assign sel_data = s_tdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    s_tready  = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_LOCK;
          grant_d = pick_oh;
          idx_d   = pick_idx;
        end
      end
      ARB_LOCK: begin
        s_tready[idx_q] = ~full;
        wr_en           = sel_vld & ~full;
        wr_data         = {sel_last, sel_data};
        if (sel_vld && !full && sel_last) begin
          state_d   = ARB_IDLE;
          grant_d   = '0;
          rr_ptr_d  = (int'(idx_q) == NUM_SRC - 1) ? '0 : idx_q + IW'(1);
          pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == ARB_LOCK);
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_fifo_wr_arb.sv
// Directed bench for axis_fifo_wr_arb: queued source packets, FIFO write log
// compared against hand-computed words, grants and cycle positions.
module tb_axis_fifo_wr_arb;

  localparam int NS = 4;
  localparam int DW = 31;
  localparam int FW = 32;
  localparam int PW = 16;

  logic             wr_clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS-1:0]    s_tvalid;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]    s_tlast;
  logic [NS-1:0]    s_tready;
  logic             full;
  logic             wr_en;
  logic [FW-1:0]    wr_data;
  logic [NS-1:0]    grant;
  logic             busy;
  logic [PW-1:0]    pkt_cnt;

  axis_fifo_wr_arb #(
    .NUM_SRC    (NS),
    .DATA_WIDTH (DW),
    .FIFO_WIDTH (FW),
    .PKT_CNT_W  (PW)
  ) dut (
    .wr_clk   (wr_clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .full     (full),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .grant    (grant),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] srcq [NS][$];
  logic [NS-1:0] gap = '0;
  logic [FW-1:0] wq[$];
  int gq[$];
  int cq[$];
  logic [FW-1:0] ew[$];
  int eg[$];
  int ec[$];
  int cyc = 0;
  int busy_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive();
    logic [31:0] w;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && !gap[i]) begin
        w = srcq[i][0];
        s_tvalid[i] = 1'b1;
        s_tlast[i]  = w[31];
        s_tdata[i*DW +: DW] = w[DW-1:0];
      end
    end
  endtask

  // One clock: sample at negedge, retire accepted beats just after posedge.
  task automatic cycle();
    logic [NS-1:0] fire;
    @(negedge wr_clk);
    fire = s_tvalid & s_tready;
    if (wr_en) begin
      wq.push_back(wr_data);
      gq.push_back(oh2idx(grant));
      cq.push_back(cyc);
    end
    if (busy) busy_cnt++;
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NS; i++) if (fire[i]) void'(srcq[i].pop_front());
    drive();
    cyc++;
  endtask

  task automatic send(input int src, input int nb, input logic [30:0] base);
    logic last;
    logic [30:0] d;
    for (int b = 0; b < nb; b++) begin
      last = (b == nb - 1);
      d = base + 31'(b);
      srcq[src].push_back({last, d});
    end
  endtask

  task automatic clr_logs();
    wq.delete(); gq.delete(); cq.delete();
    busy_cnt = 0;
    cyc = 0;
  endtask

  task automatic exp_wr(input logic [FW-1:0] w, input int g, input int c);
    ew.push_back(w); eg.push_back(g); ec.push_back(c);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwr"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size(); i++) begin
      if (i < wq.size()) begin
        chk($sformatf("%s_word%0d", tag, i), wq[i], ew[i]);
        chk($sformatf("%s_grant%0d", tag, i), gq[i], eg[i]);
        chk($sformatf("%s_cyc%0d", tag, i), cq[i], ec[i]);
      end
    end
    ew.delete(); eg.delete(); ec.delete();
  endtask

  initial begin
    logic [30:0] rr_base [5];
    int rr_src [5];

    // Reset state with every source requesting.
    full     = 1'b0;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = '1;
    #12;
    chk("rst_grant",   grant, 4'b0000);
    chk("rst_busy",    busy, 1'b0);
    chk("rst_tready",  s_tready, 4'b0000);
    chk("rst_wr_en",   wr_en, 1'b0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_pkt_cnt", pkt_cnt, 16'h0);
    chk("rst_rr_ptr",  dut.rr_ptr_q, 2'd0);
    drive();
    @(posedge wr_clk);
    #1;
    rst = 1'b0;

    // Round robin: two packets from source 0, one each from 1..3.
    clr_logs();
    send(0, 2, 31'h000); send(0, 2, 31'h010);
    send(1, 2, 31'h100); send(2, 2, 31'h200); send(3, 2, 31'h300);
    drive();
    repeat (18) cycle();
    rr_base = '{31'h000, 31'h100, 31'h200, 31'h300, 31'h010};
    rr_src  = '{0, 1, 2, 3, 0};
    for (int p = 0; p < 5; p++) begin
      exp_wr({1'b0, rr_base[p]}, rr_src[p], 1 + 3*p);
      exp_wr({1'b1, rr_base[p] + 31'h1}, rr_src[p], 2 + 3*p);
    end
    check_log("rr");
    chk("rr_pkt_cnt", pkt_cnt, 16'd5);
    chk("rr_rr_ptr", dut.rr_ptr_q, 2'd1);
    chk("rr_busy_cycles", busy_cnt, 10);

    // Backpressure: full for three cycles after the second beat.
    clr_logs();
    send(2, 4, 31'hA);
    drive();
    repeat (3) cycle();
    for (int s = 0; s < 3; s++) begin
      full = 1'b1;
      #1;
      chk($sformatf("bp_wr_en%0d", s), wr_en, 1'b0);
      chk($sformatf("bp_tready%0d", s), s_tready, 4'b0000);
      chk($sformatf("bp_grant%0d", s), grant, 4'b0100);
      cycle();
    end
    full = 1'b0;
    repeat (4) cycle();
    exp_wr(32'h0000000A, 2, 1);
    exp_wr(32'h0000000B, 2, 2);
    exp_wr(32'h0000000C, 2, 6);
    exp_wr(32'h8000000D, 2, 7);
    check_log("bp");
    chk("bp_pkt_cnt", pkt_cnt, 16'd6);
    chk("bp_rr_ptr", dut.rr_ptr_q, 2'd3);

    // Reset in the middle of a packet.
    clr_logs();
    send(0, 3, 31'h400);
    drive();
    repeat (2) cycle();
    chk("mid_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_grant",   grant, 4'b0000);
    chk("mid_busy",    busy, 1'b0);
    chk("mid_tready",  s_tready, 4'b0000);
    chk("mid_wr_en",   wr_en, 1'b0);
    chk("mid_wr_data", wr_data, 32'h0);
    chk("mid_pkt_cnt", pkt_cnt, 16'h0);
    chk("mid_rr_ptr",  dut.rr_ptr_q, 2'd0);
    for (int i = 0; i < NS; i++) srcq[i].delete();
    rst = 1'b0;
    drive();

    // Single-beat packets: source 1 twice, source 3 once.
    clr_logs();
    send(1, 1, 31'h110); send(1, 1, 31'h111); send(3, 1, 31'h310);
    drive();
    repeat (8) cycle();
    exp_wr(32'h80000110, 1, 1);
    exp_wr(32'h80000310, 3, 3);
    exp_wr(32'h80000111, 1, 5);
    check_log("sb");
    chk("sb_busy_cycles", busy_cnt, 3);

    // Source 0 drops valid mid-packet while source 1 waits.
    clr_logs();
    send(0, 3, 31'h500); send(1, 2, 31'h600);
    drive();
    repeat (2) cycle();
    gap[0] = 1'b1;
    drive();
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("gap_src1_vld%0d", s), s_tvalid[1], 1'b1);
      chk($sformatf("gap_grant%0d", s), grant, 4'b0001);
      chk($sformatf("gap_tready%0d", s), s_tready, 4'b0001);
      chk($sformatf("gap_wr_en%0d", s), wr_en, 1'b0);
      cycle();
    end
    gap[0] = 1'b0;
    drive();
    repeat (8) cycle();
    exp_wr(32'h00000500, 0, 1);
    exp_wr(32'h00000501, 0, 7);
    exp_wr(32'h80000502, 0, 8);
    exp_wr(32'h00000600, 1, 10);
    exp_wr(32'h80000601, 1, 11);
    check_log("gap");
    chk("gap_pkt_cnt", pkt_cnt, 16'd5);

    // Counter wrap from all-ones.
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    #1;
    chk("wrap_preload", pkt_cnt, 16'hFFFF);
    clr_logs();
    send(2, 1, 31'h700);
    drive();
    repeat (3) cycle();
    exp_wr(32'h80000700, 2, 1);
    check_log("wrap");
    chk("wrap_pkt_cnt", pkt_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
